// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_arbiter
// Purpose  : Arbitrates a CPU instruction-fetch port and a load/store port
//            onto a single memory bus. Data accesses have fixed priority over
//            fetches. Each access is held for WAIT_N or WAIT_S wait cycles,
//            depending on whether it continues the previous access.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
  parameter int WAIT_N = 3,
  parameter int WAIT_S = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch port
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  // load/store port
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  // memory bus
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // completion / results
  output logic        fetch_done,
  output logic [31:0] ir_out,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Counter is wide enough for the larger of the two wait settings.
  localparam int c_max_wait = (WAIT_N > WAIT_S) ? WAIT_N : WAIT_S;
  localparam int c_cnt_w    = (c_max_wait < 1) ? 1 : $clog2(c_max_wait + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_n    = c_cnt_w'(WAIT_N);
  localparam logic [c_cnt_w-1:0] c_cnt_s    = c_cnt_w'(WAIT_S);
  localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic       c_id_fetch  = 1'b0;
  localparam logic       c_id_data   = 1'b1;
  localparam logic [1:0] c_size_word = 2'b10;

  // --------------------------------------------------------------------------
  // State and latched access attributes
  // --------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        id_q;
  logic        hist_q;        // a previous access exists for sequential compare
  logic        after_done_q;  // current cycle is the one right after DONE
  logic [31:0] ir_q;
  logic [31:0] drd_q;

  // --------------------------------------------------------------------------
  // Request selection (data has fixed priority over fetch)
  // --------------------------------------------------------------------------
  logic        w_grant;
  logic        w_req_id;
  logic [31:0] w_req_addr;
  logic [1:0]  w_req_size;
  logic        w_req_we;
  logic [31:0] w_req_wdata;
  logic [31:0] w_prev_bytes;
  logic        w_seq;
  logic        w_in_access;
  logic        w_last_beat;

  assign w_grant  = (state_q == S_IDLE) && (fetch_req || data_req);
  assign w_req_id = data_req ? c_id_data : c_id_fetch;

  // Fetches are always word reads; size code 11 on the data port is a word.
  assign w_req_addr  = data_req ? data_addr : fetch_addr;
  assign w_req_size  = data_req ? ((data_size == 2'b11) ? c_size_word : data_size)
                                : c_size_word;
  assign w_req_we    = data_req & data_we;
  assign w_req_wdata = data_req ? data_wdata : 32'd0;

  // Byte length of the previous access, used to predict the next address.
  assign w_prev_bytes = (size_q == 2'b00) ? 32'd1 :
                        (size_q == 2'b01) ? 32'd2 : 32'd4;

  // Sequential only when the grant immediately follows DONE, the requester
  // is unchanged and the address continues on from the last access (wraps).
  assign w_seq = after_done_q && hist_q && (w_req_id == id_q) &&
                 (w_req_addr == (addr_q + w_prev_bytes));

  assign w_in_access = (state_q == S_ACCESS);
  assign w_last_beat = w_in_access && (cnt_q == c_cnt_zero);

  // --------------------------------------------------------------------------
  // Next-state and wait-counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant) begin
          state_d = S_ACCESS;
          cnt_d   = w_seq ? c_cnt_s : c_cnt_n;
        end
      end
      S_ACCESS: begin
        if (cnt_q == c_cnt_zero) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = c_cnt_zero;
      end
    endcase
  end

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= c_cnt_zero;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the granted request; it also serves as history for the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= 32'd0;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      wdata_q      <= 32'd0;
      id_q         <= c_id_fetch;
      hist_q       <= 1'b0;
      after_done_q <= 1'b0;
    end else begin
      after_done_q <= (state_q == S_DONE);
      if (w_grant) begin
        addr_q  <= w_req_addr;
        size_q  <= w_req_size;
        we_q    <= w_req_we;
        wdata_q <= w_req_wdata;
        id_q    <= w_req_id;
        hist_q  <= 1'b1;
      end
    end
  end

  // Capture read data on the final access cycle; stores leave results alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q  <= 32'd0;
      drd_q <= 32'd0;
    end else if (w_last_beat && !we_q) begin
      if (id_q == c_id_fetch) begin
        ir_q <= mem_rdata;
      end else begin
        drd_q <= mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: bus quiet (all zero) outside ACCESS
  // --------------------------------------------------------------------------
  assign mem_rd    = w_in_access & ~we_q;
  assign mem_wr    = w_in_access &  we_q;
  assign mem_size  = w_in_access ? size_q  : 2'b00;
  assign mem_addr  = w_in_access ? addr_q  : 32'd0;
  assign mem_wdata = w_in_access ? wdata_q : 32'd0;

  assign fetch_done = (state_q == S_DONE) && (id_q == c_id_fetch);
  assign data_done  = (state_q == S_DONE) && (id_q == c_id_data);
  assign busy       = (state_q != S_IDLE);

  assign ir_out     = ir_q;
  assign data_rdata = drd_q;

endmodule
`default_nettype wire
